pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Next-address controller for the 8-bit program counter register.
- Each cycle it computes the value loaded into the PC register: sequential +4, branch, jump, call or return target. The PC register's current output is fed back to it.
- Owns a small return-address stack (RAS) and a RUN/HALT state machine for stall and halt control of instruction fetch.
- Sits between the control unit / branch comparator and the PC register in the single-cycle datapath.

Parameters:
- AW, 8, PC/address width in bits (byte address, word-aligned).
- INC, 4, sequential increment in bytes.
- RAS_DEPTH, 4, return-address stack entries (power of 2, ≥2).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high
- pc_cur  input  AW  current PC register output
- pc_next  output  AW  value to load into the PC register next edge (combinational)
- stall  input  1  hold PC this cycle
- branch_taken  input  1  conditional branch resolved taken
- branch_target  input  AW  branch destination
- jump  input  1  unconditional jump
- call  input  1  jump and push return address
- jump_target  input  AW  destination for jump/call
- ret  input  1  return: pop RAS into PC
- halt_req  input  1  enter HALT
- resume  input  1  leave HALT
- halted  output  1  state == HALT
- ras_count  output  log2(RAS_DEPTH)+1  valid RAS entries
- ras_overflow  output  1  sticky: push while full
- ras_underflow  output  1  sticky: pop while empty

Behaviour:
- Reset (async): state=RUN, RAS pointer=0, ras_count=0, both sticky flags=0, halted=0. All RAS entries cleared to 0. pc_next is combinational, so while reset is high it evaluates to pc_cur+INC. The PC register itself resets to 0.
- FSM states RUN and HALT.
  - RUN → HALT on halt_req, unless stall is high.
  - HALT → RUN on resume.
  - halt_req is ignored in HALT. resume is ignored in RUN.
- pc_next selection, fixed priority, highest first:
  1. state==HALT, or (RUN and halt_req) → pc_cur.
  2. stall → pc_cur.
  3. ret → RAS top. If the RAS is empty: pc_cur+INC, and ras_underflow is set.
  4. call or jump → jump_target.
  5. branch_taken → branch_target.
  6. otherwise → pc_cur+INC.
- Arithmetic is modulo 2^AW: pc_cur=252 gives pc_next=0. No alignment checking; targets pass through unchanged.
- call pushes pc_cur+INC (mod 2^AW) at the clock edge, only when call is the selected source. If call and ret are both high, ret wins and there is no push.
- RAS is a circular buffer.
  - Push when full overwrites the oldest entry; ras_count stays at RAS_DEPTH; ras_overflow is set.
  - Pop when non-empty decrements ras_count.
- Push and pop are suppressed whenever case 1 or 2 selects (halt or stall).
- Sticky flags clear only on reset.
- Latency: pc_next is valid in the same cycle as its inputs. RAS and FSM updates take effect at the next rising edge.
- Reset asserted mid-operation: everything clears immediately. The first edge after release behaves as RUN with an empty RAS.

Decomposition:
- Shared package holds:
  - the PC source-select enum (SRC_HOLD, SRC_RET, SRC_JUMP, SRC_BRANCH, SRC_SEQ);
  - the FSM state enum (RUN, HALT);
  - constants AW=8 and INC=4.
- One sub-module, ras_stack: circular LIFO with push, pop, top, count, full, empty and sticky overflow/underflow outputs. The top level keeps the FSM and the priority mux.

Test Plan:
- Reset, then hold pc_cur=0 with no controls → pc_next=4. Drive pc_cur=252 → pc_next=0 (wrap).
- pc_cur=8, call=1, jump_target=64 → pc_next=64, ras_count=1. Next cycle pc_cur=64, ret=1 → pc_next=12, ras_count=0.
- Five nested calls with RAS_DEPTH=4, from pc_cur=0,16,32,48,80 → ras_overflow=1, ras_count=4. Four rets then return 84,52,36,20. A fifth ret gives pc_cur+4 and ras_underflow=1.
- pc_cur=40 with stall=1, branch_taken=1, branch_target=100 → pc_next=40. With stall=0 → pc_next=100. With jump=1 also high, jump_target=200 → pc_next=200.
- halt_req=1 at pc_cur=20 → pc_next=20, halted=1 next edge. Stays 20 for 3 cycles even with call=1, and ras_count is unchanged. resume=1 → halted=0 next edge, then pc_next=24.
- With ras_count=2, assert reset asynchronously between edges → ras_count=0, flags=0, halted=0 immediately without a clock edge.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the PC next-address sequencer.
package pc_sequencer_pkg;

  // Default PC width and sequential increment for this datapath
  localparam int AW  = 8;
  localparam int INC = 4;

  // Source chosen by the priority mux for the next PC value
  typedef enum logic [2:0] {
    SRC_HOLD,
    SRC_RET,
    SRC_JUMP,
    SRC_BRANCH,
    SRC_SEQ
  } pc_src_e;

  // Fetch control state
  typedef enum logic [0:0] {
    RUN,
    HALT
  } state_e;

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// Return-address stack: circular LIFO that overwrites its oldest entry when
// pushed while full, with sticky overflow/underflow indications.
module ras_stack #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DW-1:0]              push_data,
  output logic [DW-1:0]              top,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  // ptr is the slot the next push writes; the top of stack sits just below it.
  // Because the pointer wraps, a push while full lands on the oldest entry.
  logic [PW-1:0] ptr;
  logic [PW-1:0] top_idx;
  logic [DW-1:0] mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign top_idx = ptr - PTR_ONE;
  assign top     = mem[top_idx];
  assign full    = (count == CNT_DEPTH);
  assign empty   = (count == '0);

  // Pop takes precedence so a simultaneous request can never corrupt the stack
  assign do_pop  = pop && !empty;
  assign do_push = push && !pop;

  // Storage array: cleared on reset, written only on a push
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; count saturates at DEPTH on overwrite
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (do_push) begin
      ptr <= ptr + PTR_ONE;
      if (!full) begin
        count <= count + CNT_ONE;
      end
    end else if (do_pop) begin
      ptr   <= ptr - PTR_ONE;
      count <= count - CNT_ONE;
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_push && full) begin
        overflow <= 1'b1;
      end
      if (pop && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-address controller for the program counter: priority mux over
// hold/return/jump/branch/sequential sources, RUN/HALT fetch control and
// a return-address stack fed by calls.
module pc_sequencer #(
  parameter int AW        = pc_sequencer_pkg::AW,
  parameter int INC       = pc_sequencer_pkg::INC,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [AW-1:0]                pc_cur,
  output logic [AW-1:0]                pc_next,
  input  logic                         stall,
  input  logic                         branch_taken,
  input  logic [AW-1:0]                branch_target,
  input  logic                         jump,
  input  logic                         call,
  input  logic [AW-1:0]                jump_target,
  input  logic                         ret,
  input  logic                         halt_req,
  input  logic                         resume,
  output logic                         halted,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow,
  output logic                         ras_underflow
);

  import pc_sequencer_pkg::*;

  localparam logic [AW-1:0] INC_V = AW'(INC);

  state_e        state;
  state_e        state_nx;
  pc_src_e       src;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] ras_top;
  logic          ras_empty;
  logic          ras_push;
  logic          ras_pop;

  // Wraps naturally at 2^AW, so 252 + 4 gives 0 for an 8-bit PC
  assign pc_inc = pc_cur + INC_V;

  // Fixed-priority source selection; halt (or a halt request) and stall freeze the PC
  always_comb begin
    src = SRC_SEQ;
    if (state == HALT || halt_req || stall) begin
      src = SRC_HOLD;
    end else if (ret) begin
      src = SRC_RET;
    end else if (call || jump) begin
      src = SRC_JUMP;
    end else if (branch_taken) begin
      src = SRC_BRANCH;
    end
  end

  // Next-PC mux; a return with an empty stack falls through to sequential
  always_comb begin
    pc_next = pc_inc;
    case (src)
      SRC_HOLD:   pc_next = pc_cur;
      SRC_RET:    pc_next = ras_empty ? pc_inc : ras_top;
      SRC_JUMP:   pc_next = jump_target;
      SRC_BRANCH: pc_next = branch_target;
      default:    pc_next = pc_inc;
    endcase
  end

  // Stack traffic only happens when the call/ret is the winning source
  assign ras_push = (src == SRC_JUMP) && call;
  assign ras_pop  = (src == SRC_RET);

  ras_stack #(
    .DW    (AW),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_inc),
    .top       (ras_top),
    .count     (ras_count),
    .full      (),
    .empty     (ras_empty),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

  // RUN/HALT transitions; a stalled cycle defers the halt request
  always_comb begin
    state_nx = state;
    case (state)
      RUN:     if (halt_req && !stall) state_nx = HALT;
      HALT:    if (resume)             state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  // Fetch-control state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_nx;
    end
  end

  assign halted = (state == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

  localparam int AW = 8;

  logic          clk;
  logic          reset;
  logic [AW-1:0] pc_cur;
  logic [AW-1:0] pc_next;
  logic          stall;
  logic          branch_taken;
  logic [AW-1:0] branch_target;
  logic          jump;
  logic          call;
  logic [AW-1:0] jump_target;
  logic          ret;
  logic          halt_req;
  logic          resume;
  logic          halted;
  logic [2:0]    ras_count;
  logic          ras_overflow;
  logic          ras_underflow;

  int vectors;
  int miscompares;

  pc_sequencer #(.AW(AW), .INC(4), .RAS_DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_cur        (pc_cur),
    .pc_next       (pc_next),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .call          (call),
    .jump_target   (jump_target),
    .ret           (ret),
    .halt_req      (halt_req),
    .resume        (resume),
    .halted        (halted),
    .ras_count     (ras_count),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic clearControls();
    stall = 0; branch_taken = 0; branch_target = 0; jump = 0; call = 0;
    jump_target = 0; ret = 0; halt_req = 0; resume = 0;
  endtask

  logic [AW-1:0] call_pcs [5];
  logic [AW-1:0] ret_exp  [4];

  initial begin
    vectors = 0;
    miscompares = 0;
    call_pcs = '{8'd0, 8'd16, 8'd32, 8'd48, 8'd80};
    ret_exp  = '{8'd84, 8'd52, 8'd36, 8'd20};
    clearControls();
    pc_cur = 0;
    reset = 1;
    #1;
    checkOutput("pc_next_in_reset", 32'(pc_next), 32'd4);
    applyStimulus();
    applyStimulus();
    reset = 0;
    #1;
    checkOutput("reset_halted", 32'(halted), 32'd0);
    checkOutput("reset_count", 32'(ras_count), 32'd0);
    checkOutput("reset_ovf", 32'(ras_overflow), 32'd0);
    checkOutput("reset_unf", 32'(ras_underflow), 32'd0);

    // Sequential increment and wrap
    pc_cur = 0; #1;
    checkOutput("seq_0", 32'(pc_next), 32'd4);
    pc_cur = 252; #1;
    checkOutput("seq_wrap", 32'(pc_next), 32'd0);

    // Call then return
    pc_cur = 8; call = 1; jump_target = 64; #1;
    checkOutput("call_target", 32'(pc_next), 32'd64);
    applyStimulus();
    checkOutput("call_count", 32'(ras_count), 32'd1);
    call = 0; pc_cur = 64; ret = 1; #1;
    checkOutput("ret_target", 32'(pc_next), 32'd12);
    applyStimulus();
    checkOutput("ret_count", 32'(ras_count), 32'd0);
    ret = 0;

    // Five nested calls overflow the 4-deep stack, dropping the oldest (4)
    for (int i = 0; i < 5; i++) begin
      pc_cur = call_pcs[i]; call = 1; jump_target = 8'd128; #1;
      applyStimulus();
    end
    call = 0;
    checkOutput("ovf_count", 32'(ras_count), 32'd4);
    checkOutput("ovf_flag", 32'(ras_overflow), 32'd1);
    pc_cur = 200; ret = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput($sformatf("nested_ret%0d", i), 32'(pc_next), 32'(ret_exp[i]));
      applyStimulus();
    end
    checkOutput("drained_count", 32'(ras_count), 32'd0);
    checkOutput("unf_before", 32'(ras_underflow), 32'd0);
    #1;
    checkOutput("empty_ret", 32'(pc_next), 32'd204);
    applyStimulus();
    checkOutput("unf_flag", 32'(ras_underflow), 32'd1);
    checkOutput("unf_count", 32'(ras_count), 32'd0);
    ret = 0;

    // Stall beats branch; branch; jump beats branch (no push on jump)
    pc_cur = 40; stall = 1; branch_taken = 1; branch_target = 100; #1;
    checkOutput("stall_hold", 32'(pc_next), 32'd40);
    stall = 0; #1;
    checkOutput("branch", 32'(pc_next), 32'd100);
    jump = 1; jump_target = 200; #1;
    checkOutput("jump_over_branch", 32'(pc_next), 32'd200);
    applyStimulus();
    checkOutput("jump_no_push", 32'(ras_count), 32'd0);
    clearControls();

    // Stalled call must not push; stalled halt request must not halt
    pc_cur = 60; stall = 1; call = 1; jump_target = 8; halt_req = 1; #1;
    applyStimulus();
    checkOutput("stall_no_push", 32'(ras_count), 32'd0);
    checkOutput("stall_no_halt", 32'(halted), 32'd0);
    clearControls();

    // Halt, stay frozen under call, then resume
    pc_cur = 20; halt_req = 1; #1;
    checkOutput("halt_req_hold", 32'(pc_next), 32'd20);
    applyStimulus();
    checkOutput("halted_set", 32'(halted), 32'd1);
    halt_req = 0; call = 1; jump_target = 64;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("halt_hold%0d", i), 32'(pc_next), 32'd20);
      applyStimulus();
      checkOutput($sformatf("halt_count%0d", i), 32'(ras_count), 32'd0);
    end
    call = 0; resume = 1; #1;
    checkOutput("resume_hold", 32'(pc_next), 32'd20);
    applyStimulus();
    checkOutput("halted_clr", 32'(halted), 32'd0);
    resume = 0; #1;
    checkOutput("after_resume", 32'(pc_next), 32'd24);

    // Build two entries, halt, then reset asynchronously mid-cycle
    for (int i = 0; i < 2; i++) begin
      pc_cur = call_pcs[i]; call = 1; jump_target = 8'd128; #1;
      applyStimulus();
    end
    call = 0;
    checkOutput("pre_reset_count", 32'(ras_count), 32'd2);
    halt_req = 1;
    applyStimulus();
    halt_req = 0;
    checkOutput("pre_reset_halted", 32'(halted), 32'd1);
    #2;
    reset = 1; #1;
    checkOutput("async_count", 32'(ras_count), 32'd0);
    checkOutput("async_halted", 32'(halted), 32'd0);
    checkOutput("async_ovf", 32'(ras_overflow), 32'd0);
    checkOutput("async_unf", 32'(ras_underflow), 32'd0);
    applyStimulus();
    reset = 0;

    // First edge after release runs with an empty stack
    pc_cur = 100; call = 1; jump_target = 36; #1;
    checkOutput("post_reset_call", 32'(pc_next), 32'd36);
    applyStimulus();
    checkOutput("post_reset_count", 32'(ras_count), 32'd1);
    call = 0; pc_cur = 36; ret = 1; #1;
    checkOutput("post_reset_ret", 32'(pc_next), 32'd104);
    applyStimulus();
    clearControls();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
